// File: rtl/scope_pkg.sv
// Shared types and default sizes for the frame-synchronous scope capture block.
package scope_pkg;

  localparam int unsigned SCOPE_WS     = 16;
  localparam int unsigned SCOPE_DEPTH  = 640;
  localparam int unsigned SCOPE_DECIM  = 1;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } scope_state_t;

  typedef logic signed [15:0] audio_t;

endpackage

// File: rtl/scope_bank_ram.sv
// Double-buffered sample store: two banks of DEPTH words of {L,R}, bank bit is the address MSB.
// One write port (back bank), one registered read port (front bank).
module scope_bank_ram #(
  parameter int unsigned WS     = 16,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                iCLK_50,
  input  logic                iWE,
  input  logic                iWBANK,
  input  logic [ADDR_W-1:0]   iWADDR,
  input  logic [2*WS-1:0]     iWDATA,
  input  logic                iRBANK,
  input  logic [ADDR_W-1:0]   iRADDR,
  output logic [2*WS-1:0]     oRDATA
);

  logic [2*WS-1:0] mem [0:1][0:DEPTH-1];

  // Write port plus registered read; out-of-range reads return 0 instead of indexing past the end.
  always_ff @(posedge iCLK_50) begin
    if (iWE) begin
      mem[iWBANK][iWADDR] <= iWDATA;
    end
    if ({1'b0, iRADDR} < (ADDR_W + 1)'(DEPTH)) begin
      oRDATA <= mem[iRBANK][iRADDR];
    end else begin
      oRDATA <= '0;
    end
  end

endmodule

// File: rtl/dsp_scope_capture.sv
// Frame-synchronous stereo capture buffer feeding the wave renderers.
// Captures DEPTH decimated samples into the back bank, swaps banks on the next VSync once full.
// Optional build macro SCOPE_TRIGGER_EN: ARM waits for a rising zero-crossing on L, with a
// strobe-count timeout forcing the capture.
module dsp_scope_capture
  import scope_pkg::*;
#(
  parameter int unsigned WS           = SCOPE_WS,
  parameter int unsigned DEPTH        = SCOPE_DEPTH,
  parameter int unsigned DECIM        = SCOPE_DECIM,
`ifdef SCOPE_TRIGGER_EN
  parameter int unsigned TRIG_TIMEOUT = 2048,
`endif
  localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
  input  logic                 iCLK_50,
  input  logic                 iRST_N,
  input  logic                 iLRCK,
  input  logic signed [WS-1:0] iL,
  input  logic signed [WS-1:0] iR,
  input  logic                 iVS,
  input  logic [ADDR_W-1:0]    iRD_ADDR,
  output logic signed [WS-1:0] oRD_L,
  output logic signed [WS-1:0] oRD_R,
  output logic                 oSWAPPED,
  output logic                 oBANK,
  output logic [1:0]           oSTATE
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [1:0]        lrckSync, vsSync;
  logic              lrckPrev, vsPrev;
  logic              sampleStb, vsEdge, storeStb, swap, trigHit;
  logic [7:0]        decimQ;
  scope_state_t      stateQ, stateD;
  logic [ADDR_W-1:0] wrPtrQ, wrPtrD;
  logic              bankQ, bankD, fvQ, fvD, we;
  logic              addrOkQ;
  logic [2*WS-1:0]   ramData;

  // Two-stage synchronisers and previous-value flops for the async LRCK and VS pins.
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      lrckSync <= '0;
      vsSync   <= '0;
      lrckPrev <= 1'b0;
      vsPrev   <= 1'b0;
    end else begin
      lrckSync <= {lrckSync[0], iLRCK};
      vsSync   <= {vsSync[0], iVS};
      lrckPrev <= lrckSync[1];
      vsPrev   <= vsSync[1];
    end
  end

  assign sampleStb = lrckSync[1] & ~lrckPrev;
  assign vsEdge    = vsSync[1] & ~vsPrev;
  assign storeStb  = sampleStb && (decimQ == 8'd0);
  assign swap      = (stateQ == FULL) && vsEdge;

  // Decimator: counts every sample strobe modulo DECIM, restarts on a bank swap.
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N || swap) begin
      decimQ <= 8'd0;
    end else if (sampleStb) begin
      decimQ <= (decimQ == 8'(DECIM - 1)) ? 8'd0 : decimQ + 8'd1;
    end
  end

`ifdef SCOPE_TRIGGER_EN
  logic signed [WS-1:0] prevLQ;
  logic [11:0]          toutQ;

  assign trigHit = (prevLQ[WS-1] && !iL[WS-1]) || (toutQ == 12'(TRIG_TIMEOUT - 1));

  // Trigger history: last stored L, and count of untriggered strobes spent waiting in ARM.
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      prevLQ <= '0;
      toutQ  <= '0;
    end else begin
      if (storeStb && !swap) begin
        prevLQ <= iL;
      end
      if (swap) begin
        toutQ <= '0;
      end else if ((stateQ == ARM) && storeStb && !trigHit) begin
        toutQ <= toutQ + 12'd1;
      end
    end
  end
`else
  assign trigHit = 1'b1;
`endif

  // Capture FSM next state; writes always target the back bank at wrPtrQ.
  always_comb begin
    stateD = stateQ;
    wrPtrD = wrPtrQ;
    bankD  = bankQ;
    fvD    = fvQ;
    we     = 1'b0;
    case (stateQ)
      ARM: begin
        if (storeStb && trigHit) begin
          we     = 1'b1;
          wrPtrD = wrPtrQ + 1'b1;
          stateD = CAPTURE;
        end
      end
      CAPTURE: begin
        if (storeStb) begin
          we = 1'b1;
          if (wrPtrQ == LastAddr) begin
            stateD = FULL;
          end else begin
            wrPtrD = wrPtrQ + 1'b1;
          end
        end
      end
      FULL: begin
        // Strobes are ignored here, so a coincident strobe is dropped by the swap.
        if (vsEdge) begin
          bankD  = ~bankQ;
          fvD    = 1'b1;
          wrPtrD = '0;
          stateD = ARM;
        end
      end
      default: stateD = ARM;
    endcase
  end

  // FSM state, write pointer, bank select and swap pulse.
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      stateQ   <= ARM;
      wrPtrQ   <= '0;
      bankQ    <= 1'b0;
      fvQ      <= 1'b0;
      oSWAPPED <= 1'b0;
    end else begin
      stateQ   <= stateD;
      wrPtrQ   <= wrPtrD;
      bankQ    <= bankD;
      fvQ      <= fvD;
      oSWAPPED <= swap;
    end
  end

  scope_bank_ram #(
    .WS    (WS),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .iCLK_50(iCLK_50),
    .iWE    (we),
    .iWBANK (~bankQ),
    .iWADDR (wrPtrQ),
    .iWDATA ({iL, iR}),
    .iRBANK (bankQ),
    .iRADDR (iRD_ADDR),
    .oRDATA (ramData)
  );

  // Output stage: address range tracked alongside the RAM read, masked until a bank is valid.
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      addrOkQ <= 1'b0;
      oRD_L   <= '0;
      oRD_R   <= '0;
    end else begin
      addrOkQ <= ({1'b0, iRD_ADDR} < (ADDR_W + 1)'(DEPTH));
      if (addrOkQ && fvQ) begin
        oRD_L <= ramData[2*WS-1:WS];
        oRD_R <= ramData[WS-1:0];
      end else begin
        oRD_L <= '0;
        oRD_R <= '0;
      end
    end
  end

  assign oBANK  = bankQ;
  assign oSTATE = stateQ;

endmodule

// File: tb/tb_dsp_scope_capture.sv
// Bench for dsp_scope_capture: unit 0 runs DECIM=1, unit 1 runs DECIM=4 on the same stimulus.
`timescale 1ns/1ps
module tb_dsp_scope_capture;

  localparam int DEPTH = 640;
`ifdef SCOPE_TRIGGER_EN
  localparam int TOUT = 2048;
`endif

  typedef struct {
    int    addr;
    int    expL;
    int    expR;
    string name;
  } vec_t;

  logic clk = 1'b0, rstN = 1'b0, lrck = 1'b0, vs = 1'b0;
  logic signed [15:0] iL = '0, iR = '0;
  logic [9:0] rdAddr = '0;
  logic signed [15:0] rdL0, rdR0, rdL1, rdR1;
  logic sw0, sw1, bank0, bank1;
  logic [1:0] state0, state1;

  int dec [2] = '{1, 4};
  int mCapL [2][DEPTH];
  int mCapR [2][DEPTH];
  int mFrL  [2][DEPTH];
  int mFrR  [2][DEPTH];
  int mCapN [2], mStb [2], mArm [2], mPrev [2], mSwaps [2];
  bit mFv [2], mBank [2];

  int total = 0, bad = 0, wide = 0;
  int swSeen [2] = '{0, 0};
  bit swPrev [2] = '{1'b0, 1'b0};

  always #10 clk = ~clk;

  dsp_scope_capture u_dut0 (
    .iCLK_50(clk), .iRST_N(rstN), .iLRCK(lrck), .iL(iL), .iR(iR), .iVS(vs),
    .iRD_ADDR(rdAddr), .oRD_L(rdL0), .oRD_R(rdR0), .oSWAPPED(sw0), .oBANK(bank0),
    .oSTATE(state0)
  );

  dsp_scope_capture #(.DECIM(4)) u_dut1 (
    .iCLK_50(clk), .iRST_N(rstN), .iLRCK(lrck), .iL(iL), .iR(iR), .iVS(vs),
    .iRD_ADDR(rdAddr), .oRD_L(rdL1), .oRD_R(rdR1), .oSWAPPED(sw1), .oBANK(bank1),
    .oSTATE(state1)
  );

  // Count swap pulses and any pulse lasting more than one clock.
  always @(negedge clk) begin
    if (sw0) swSeen[0]++;
    if (sw1) swSeen[1]++;
    if ((sw0 && swPrev[0]) || (sw1 && swPrev[1])) wide++;
    swPrev[0] = sw0;
    swPrev[1] = sw1;
  end

  initial begin
    #1_900_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mCapN[u] = 0; mStb[u] = 0; mArm[u] = 0; mPrev[u] = 0; mFv[u] = 0; mBank[u] = 0;
    end
  endtask

  // Reference: a capture is a list of decimated samples; VS publishes it only once complete.
  task automatic model_event(input bit s, input bit v, input int l, input int r);
    bit store, go;
    for (int u = 0; u < 2; u++) begin
      if (v && mCapN[u] == DEPTH) begin
        for (int k = 0; k < DEPTH; k++) begin
          mFrL[u][k] = mCapL[u][k];
          mFrR[u][k] = mCapR[u][k];
        end
        mFv[u] = 1'b1; mBank[u] = ~mBank[u]; mCapN[u] = 0; mStb[u] = 0; mArm[u] = 0;
        mSwaps[u]++;
      end else if (s) begin
        store = (mStb[u] % dec[u]) == 0;
        mStb[u]++;
        if (store) begin
          go = mCapN[u] < DEPTH;
`ifdef SCOPE_TRIGGER_EN
          if (mCapN[u] == 0) begin
            go = (mPrev[u] < 0 && l >= 0) || (mArm[u] == TOUT - 1);
            if (!go) mArm[u]++;
          end
`endif
          if (go) begin
            mCapL[u][mCapN[u]] = l;
            mCapR[u][mCapN[u]] = r;
            mCapN[u]++;
          end
          mPrev[u] = l;
        end
      end
    end
  endtask

  task automatic smp(input int l, input int r);
    @(negedge clk);
    iL = 16'(l); iR = 16'(r); lrck = 1'b1;
    repeat (3) @(negedge clk);
    lrck = 1'b0;
    repeat (3) @(negedge clk);
    model_event(1'b1, 1'b0, l, r);
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
    model_event(1'b0, 1'b1, 0, 0);
  endtask

  // LRCK and VS rise together, so both edges are detected on the same clock.
  task automatic both(input int l, input int r);
    @(negedge clk);
    iL = 16'(l); iR = 16'(r); lrck = 1'b1; vs = 1'b1;
    repeat (3) @(negedge clk);
    lrck = 1'b0; vs = 1'b0;
    repeat (3) @(negedge clk);
    model_event(1'b1, 1'b1, l, r);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    model_reset();
  endtask

  // A negative sample ahead of a positive run arms the zero-crossing trigger.
  task automatic pre();
`ifdef SCOPE_TRIGGER_EN
    smp(-1, 0);
`endif
  endtask

  task automatic rd(input int a);
    @(negedge clk);
    rdAddr = 10'(a);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int exp_state(input int u);
    if (mCapN[u] == 0) return 0;
    if (mCapN[u] == DEPTH) return 2;
    return 1;
  endfunction

  task automatic chk_status(input string nm);
    chk($sformatf("%s_state_u0", nm), int'(state0), exp_state(0));
    chk($sformatf("%s_state_u1", nm), int'(state1), exp_state(1));
    chk($sformatf("%s_bank_u0", nm), int'(bank0), int'(mBank[0]));
    chk($sformatf("%s_bank_u1", nm), int'(bank1), int'(mBank[1]));
    chk($sformatf("%s_swaps_u0", nm), swSeen[0], mSwaps[0]);
    chk($sformatf("%s_swaps_u1", nm), swSeen[1], mSwaps[1]);
  endtask

  task automatic chk_unit(input string nm, input int u, input int a);
    int eL, eR, aL, aR;
    eL = (a < DEPTH && mFv[u]) ? mFrL[u][a] : 0;
    eR = (a < DEPTH && mFv[u]) ? mFrR[u][a] : 0;
    aL = (u == 0) ? int'(rdL0) : int'(rdL1);
    aR = (u == 0) ? int'(rdR0) : int'(rdR1);
    chk($sformatf("%s_a%0d_L_u%0d", nm, a, u), aL, eL);
    chk($sformatf("%s_a%0d_R_u%0d", nm, a, u), aR, eR);
  endtask

  task automatic rd_model(input string nm, input int a);
    rd(a);
    chk_unit(nm, 0, a);
    chk_unit(nm, 1, a);
  endtask

  initial begin
    vec_t t2 [6];
    vec_t t3 [4];
    vec_t t5 [5];
    int ra [4];
    int n, rl, rr;

    t2[0] = '{0, 0, 0, "t2_a0"};       t2[1] = '{5, 5, -5, "t2_a5"};
    t2[2] = '{320, 320, -320, "t2_mid"}; t2[3] = '{639, 639, -639, "t2_last"};
    t2[4] = '{640, 0, 0, "t2_a640"};   t2[5] = '{1023, 0, 0, "t2_a1023"};
    t3[0] = '{0, 1000, -1000, "t3_a0"}; t3[1] = '{99, 1099, -1099, "t3_a99"};
    t3[2] = '{100, 1100, -1100, "t3_a100"}; t3[3] = '{639, 1639, -1639, "t3_a639"};
    t5[0] = '{0, 0, 0, "t5_a0"};       t5[1] = '{1, 4, -4, "t5_a1"};
    t5[2] = '{100, 400, -400, "t5_a100"}; t5[3] = '{639, 2556, -2556, "t5_a639"};
    t5[4] = '{700, 0, 0, "t5_a700"};
    ra = '{0, 5, 639, 700};
    for (int u = 0; u < 2; u++) mSwaps[u] = 0;

    // Power-on reset.
    rstN = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b1;
    model_reset();
    chk_status("por");
    chk("por_state_arm", int'(state0), 0);
    for (int i = 0; i < 4; i++) rd_model("por", ra[i]);

    // Reset in the middle of a capture.
    for (int i = 0; i < 50; i++) smp(i + 1, i + 1);
    chk_status("mid");
    reset_pulse();
    chk_status("midrst");
    chk("midrst_state_arm", int'(state0), 0);
    chk("midrst_bank0", int'(bank0), 0);
    for (int i = 0; i < 4; i++) rd_model("midrst", ra[i]);

    // Free-run ramp, one full frame, then swap.
    pre();
    for (int i = 0; i < DEPTH; i++) smp(i, -i);
    chk_status("t2full");
    vs_pulse();
    chk_status("t2swap");
    chk("t2_bank_after_swap", int'(bank0), 1);
    for (int i = 0; i < 6; i++) begin
      rd(t2[i].addr);
      chk({t2[i].name, "_L"}, int'(rdL0), t2[i].expL);
      chk({t2[i].name, "_R"}, int'(rdR0), t2[i].expR);
      chk_unit(t2[i].name, 1, t2[i].addr);
    end

    // VS mid-capture is ignored and the capture resumes where it was.
    pre();
    for (int i = 0; i < 100; i++) smp(1000 + i, -(1000 + i));
    vs_pulse();
    chk_status("t3vs");
    chk("t3_bank_held", int'(bank0), 1);
    chk("t3_state_capture", int'(state0), 1);
    for (int i = 100; i < DEPTH; i++) smp(1000 + i, -(1000 + i));
    chk_status("t3full");
    vs_pulse();
    chk("t3_bank_swapped", int'(bank0), 0);
    for (int i = 0; i < 4; i++) begin
      rd(t3[i].addr);
      chk({t3[i].name, "_L"}, int'(rdL0), t3[i].expL);
      chk({t3[i].name, "_R"}, int'(rdR0), t3[i].expR);
      chk_unit(t3[i].name, 1, t3[i].addr);
    end

    // Decimation by 4 on unit 1.
    reset_pulse();
    pre();
    for (int i = 0; i < 4 * DEPTH; i++) smp(i, -i);
    vs_pulse();
    chk_status("t5");
    for (int i = 0; i < 5; i++) begin
      rd(t5[i].addr);
`ifndef SCOPE_TRIGGER_EN
      chk({t5[i].name, "_L"}, int'(rdL1), t5[i].expL);
      chk({t5[i].name, "_R"}, int'(rdR1), t5[i].expR);
`endif
      chk_unit(t5[i].name, 0, t5[i].addr);
      chk_unit(t5[i].name, 1, t5[i].addr);
    end

    // Coincident strobe and VS: first on the last write, then while FULL.
    pre();
    for (int i = 0; i < DEPTH - 1; i++) smp(3000 + i, i);
    both(5555, 1);
    chk_status("t6last");
`ifndef SCOPE_TRIGGER_EN
    chk("t6_state_full", int'(state0), 2);
`endif
    both(7777, 2);
    chk_status("t6swap");
    rd_model("t6front", 0);
    rd(639);
`ifndef SCOPE_TRIGGER_EN
    chk("t6_last_write_L", int'(rdL0), 5555);
`endif
    chk_unit("t6front", 0, 639);
    smp(8888, 3);
    for (int i = 0; i < DEPTH - 1; i++) smp(4000 + i, i);
    vs_pulse();
    chk_status("t6next");
    rd(0);
`ifndef SCOPE_TRIGGER_EN
    chk("t6_next_a0_L", int'(rdL0), 8888);
`endif
    chk_unit("t6next", 0, 0);
    chk_unit("t6next", 1, 0);

`ifdef SCOPE_TRIGGER_EN
    // Zero-crossing trigger and forced capture on timeout.
    reset_pulse();
    smp(-3, 0); smp(-1, 0); smp(2, 0);
    for (int i = 0; i < DEPTH; i++) smp(4 + i, 0);
    vs_pulse();
    rd(0);
    chk("t4_trig_a0_L", int'(rdL0), 2);
    chk_unit("t4trig", 1, 0);
    reset_pulse();
    for (int i = 0; i < TOUT + DEPTH; i++) smp(-5, i);
    vs_pulse();
    rd(0);
    chk("t4_tout_a0_R", int'(rdR0), TOUT - 1);
    chk_unit("t4tout", 1, 0);
`endif

    // Random frames with occasional early VS, checked against the reference.
    for (int rnd = 0; rnd < 3; rnd++) begin
      n = int'($urandom_range(500, 720));
      for (int i = 0; i < n; i++) begin
        rl = int'($urandom_range(0, 65535)) - 32768;
        rr = int'($urandom_range(0, 65535)) - 32768;
        smp(rl, rr);
        if ($urandom_range(0, 199) == 0) vs_pulse();
      end
      vs_pulse();
      chk_status($sformatf("rnd%0d", rnd));
      rd_model("rnd", 0);
      rd_model("rnd", 639);
      rd_model("rnd", 640);
      for (int k = 0; k < 5; k++) rd_model("rnd", int'($urandom_range(0, 1023)));
    end

    chk("swap_pulse_width", wide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
